// File: rtl/pb_autorepeat_pkg.sv
// Shared types for the pushbutton conditioner: FSM state encoding reused by other button logic.
package pb_autorepeat_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

endpackage

// File: rtl/pb_autorepeat_if.sv
// Button-side bundle: raw pin and repeat enable in, conditioned level and strobes out.
interface pb_autorepeat_if;

  logic PB;
  logic EN;
  logic PB_state;
  logic PB_down;
  logic PB_up;
  logic PB_rep;
  logic PB_evt;

  modport master (
    output PB, EN,
    input  PB_state, PB_down, PB_up, PB_rep, PB_evt
  );

  modport slave (
    input  PB, EN,
    output PB_state, PB_down, PB_up, PB_rep, PB_evt
  );

endinterface

// File: rtl/pb_sync.sv
// Two-flop synchroniser for an asynchronous input; both stages reset to RST_VAL.
module pb_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pb_autorepeat.sv
// Pushbutton conditioner: synchronise, debounce, then emit press/release/auto-repeat strobes.
module pb_autorepeat
  import pb_autorepeat_pkg::*;
#(
  parameter int unsigned DB_CYC   = 50000,
  parameter int unsigned HOLD_CYC = 6000000,
  parameter int unsigned REP_CYC  = 1200000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic           CLK,
  input  logic           RST,
  pb_autorepeat_if.slave bus
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync_n;
  logic             raw;
  logic             mismatch;
  logic             db_done;
  logic             rise_c;
  logic             fall_c;
  logic [CNT_W-1:0] db_cnt;
  logic             pb_state;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] rc;
  logic [CNT_W-1:0] rc_next;
  logic             down_c;
  logic             up_c;
  logic             rep_c;
  logic             down_q;
  logic             up_q;
  logic             rep_q;
  logic             evt_q;

  // Released level is 1 on the active-low pin, so the synchroniser resets high.
  pb_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (bus.PB),
    .q   (sync_n)
  );

  assign raw      = ~sync_n;
  assign mismatch = (raw != pb_state);
  assign db_done  = mismatch && (db_cnt == DB_LAST);
  assign rise_c   = db_done && !pb_state;
  assign fall_c   = db_done &&  pb_state;

  // Debouncer: the level follows raw only after DB_CYC consecutive mismatching cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      db_cnt   <= '0;
      pb_state <= 1'b0;
    end else begin
      if (!mismatch || db_done) db_cnt <= '0;
      else                      db_cnt <= db_cnt + CNT_ONE;
      if (db_done) pb_state <= ~pb_state;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise_c) state_next = HOLD;
      HOLD: begin
        if (fall_c)                             state_next = IDLE;
        else if ((rc == HOLD_LAST) && bus.EN)   state_next = REPEAT;
      end
      REPEAT:  if (fall_c) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Release takes priority over a due repeat, so the two never strobe together.
  always_comb begin
    down_c  = 1'b0;
    up_c    = 1'b0;
    rep_c   = 1'b0;
    rc_next = rc;
    case (state)
      IDLE: begin
        if (rise_c) begin
          down_c  = 1'b1;
          rc_next = '0;
        end
      end
      HOLD: begin
        if (fall_c) begin
          up_c    = 1'b1;
          rc_next = '0;
        end else if (rc == HOLD_LAST) begin
          if (bus.EN) begin
            rep_c   = 1'b1;
            rc_next = '0;
          end
        end else begin
          rc_next = rc + CNT_ONE;
        end
      end
      REPEAT: begin
        if (fall_c) begin
          up_c    = 1'b1;
          rc_next = '0;
        end else if (bus.EN) begin
          if (rc == REP_LAST) begin
            rep_c   = 1'b1;
            rc_next = '0;
          end else begin
            rc_next = rc + CNT_ONE;
          end
        end
      end
      default: rc_next = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rc     <= '0;
      down_q <= 1'b0;
      up_q   <= 1'b0;
      rep_q  <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      rc     <= rc_next;
      down_q <= down_c;
      up_q   <= up_c;
      rep_q  <= rep_c;
      evt_q  <= down_c | rep_c;
    end
  end

  assign bus.PB_state = pb_state;
  assign bus.PB_down  = down_q;
  assign bus.PB_up    = up_q;
  assign bus.PB_rep   = rep_q;
  assign bus.PB_evt   = evt_q;

endmodule

// File: tb/tb_pb_autorepeat.sv
// Directed bench for pb_autorepeat with DB_CYC=4, HOLD_CYC=10, REP_CYC=3, CNT_W=8.
module tb_pb_autorepeat;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pb_autorepeat_if bus ();

  pb_autorepeat #(
    .DB_CYC   (4),
    .HOLD_CYC (10),
    .REP_CYC  (3),
    .CNT_W    (8)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic st, input logic dn,
                           input logic up, input logic rp);
    check({tag, ".state"}, bus.PB_state, st);
    check({tag, ".down"},  bus.PB_down,  dn);
    check({tag, ".up"},    bus.PB_up,    up);
    check({tag, ".rep"},   bus.PB_rep,   rp);
    check({tag, ".evt"},   bus.PB_evt,   dn | rp);
  endtask

  // Advance one cycle; inputs change and outputs are sampled on the falling edge.
  task automatic tick_chk(input string tag, input logic st, input logic dn,
                          input logic up, input logic rp);
    @(negedge clk);
    check_all(tag, st, dn, up, rp);
  endtask

  initial begin
    rst    = 1'b1;
    bus.PB = 1'b1;
    bus.EN = 1'b1;
    repeat (2) tick_chk("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) tick_chk("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Three-cycle glitch must not get through the debouncer.
    bus.PB = 1'b0;
    repeat (3) tick_chk("glitch", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.PB = 1'b1;
    repeat (8) tick_chk("glitch_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Press with EN high: down at +6, repeats at down+10, +13, +16, ...
    bus.PB = 1'b0;
    repeat (5) tick_chk("press_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    tick_chk("press_down", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++)
      tick_chk("rep_en", 1'b1, 1'b0, 1'b0, (k >= 10) && ((k - 10) % 3 == 0));
    bus.PB = 1'b1;
    for (int k = 21; k <= 32; k++)
      tick_chk("release", k < 26, 1'b0, k == 26, (k < 26) && ((k - 10) % 3 == 0));

    // EN low through HOLD, freeze in REPEAT, then release on a due repeat.
    bus.EN = 1'b0;
    bus.PB = 1'b0;
    repeat (5) tick_chk("gate_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    tick_chk("gate_down", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 43; k++) begin
      tick_chk("en_gate", k < 39, 1'b0, k == 39,
               (k == 16) || (k == 19) || (k == 22) || (k == 30) || (k == 33) || (k == 36));
      if (k == 15) bus.EN = 1'b1;
      if (k == 23) bus.EN = 1'b0;
      if (k == 28) bus.EN = 1'b1;
      if (k == 33) bus.PB = 1'b1;
    end

    // Asynchronous reset while held: outputs drop before the next edge.
    bus.PB = 1'b0;
    repeat (5) tick_chk("pre_rst_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    tick_chk("pre_rst_down", 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) tick_chk("pre_rst_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.PB = 1'b1;
    repeat (2) tick_chk("in_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (6) tick_chk("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // Button held through reset release: exactly one press, six cycles later.
    bus.PB = 1'b0;
    rst    = 1'b1;
    repeat (2) tick_chk("held_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (5) tick_chk("held_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    tick_chk("held_down", 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) tick_chk("held_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    bus.PB = 1'b1;
    repeat (5) tick_chk("held_rel_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    tick_chk("held_up", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) tick_chk("held_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
